// File: rtl/product_bcd_formatter.sv
// product_bcd_formatter
//   Converts a signed two's-complement product into sign + three BCD digits
//   using iterative shift-add-3 (double-dabble), one magnitude bit per clock.
//   Feeds the seven-segment display mux, so leading-zero blank flags are
//   provided alongside the digits.
//
// Ports
//   Clock          system clock, rising edge
//   Reset          synchronous active-high reset
//   Start          request a conversion of Product (sampled only in IDLE)
//   Product        signed WIDTH-bit value to convert
//   Busy           high while a conversion is in progress
//   Done           one-cycle pulse when the digit outputs update
//   Negative       sign of the last converted value
//   Hundreds/Tens/Ones  BCD digits of the magnitude
//   BlankHundreds  Hundreds == 0
//   BlankTens      Hundreds == 0 and Tens == 0
module product_bcd_formatter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Product,
    output logic             Busy,
    output logic             Done,
    output logic             Negative,
    output logic [3:0]       Hundreds,
    output logic [3:0]       Tens,
    output logic [3:0]       Ones,
    output logic             BlankHundreds,
    output logic             BlankTens
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [11:0]       scratch_q, scratch_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              neg_q, neg_d;
    logic [3:0]        hund_q, hund_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        ones_q, ones_d;
    logic              blank_h_q, blank_h_d;
    logic              blank_t_q, blank_t_d;

    logic [3:0]        adj_tens, adj_ones;

    // Magnitude never exceeds 256, so the hundreds digit is at most 1 before
    // the final shift and never needs the add-3 correction.
    always_comb begin
        adj_tens = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
        adj_ones = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        hund_d    = hund_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        blank_h_d = blank_h_q;
        blank_t_d = blank_t_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    sign_d    = Product[WIDTH-1];
                    // Most negative input wraps to 2^(WIDTH-1) as unsigned.
                    mag_d     = Product[WIDTH-1] ? ({WIDTH{1'b0}} - Product) : Product;
                    scratch_d = 12'd0;
                    cnt_d     = CntW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = {scratch_q[10:8], adj_tens, adj_ones, mag_q[WIDTH-1]};
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                neg_d     = sign_q;
                hund_d    = scratch_q[11:8];
                tens_d    = scratch_q[7:4];
                ones_d    = scratch_q[3:0];
                blank_h_d = (scratch_q[11:8] == 4'd0);
                blank_t_d = (scratch_q[11:4] == 8'd0);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            hund_q    <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            blank_h_q <= 1'b1;
            blank_t_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            neg_q     <= neg_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            blank_h_q <= blank_h_d;
            blank_t_q <= blank_t_d;
        end
    end

    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Negative      = neg_q;
    assign Hundreds      = hund_q;
    assign Tens          = tens_q;
    assign Ones          = ones_q;
    assign BlankHundreds = blank_h_q;
    assign BlankTens     = blank_t_q;

endmodule

// File: tb/tb_product_bcd_formatter.sv
module tb_product_bcd_formatter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] Product = 8'h00;
    logic       Busy, Done, Negative, BlankHundreds, BlankTens;
    logic [3:0] Hundreds, Tens, Ones;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int done_count = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    // {Negative, Hundreds, Tens, Ones, BlankHundreds, BlankTens}
    logic [14:0] exp_q[$];
    logic [14:0] last_exp = {1'b0, 12'd0, 1'b1, 1'b1};

    product_bcd_formatter #(.WIDTH(8)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Start         (Start),
        .Product       (Product),
        .Busy          (Busy),
        .Done          (Done),
        .Negative      (Negative),
        .Hundreds      (Hundreds),
        .Tens          (Tens),
        .Ones          (Ones),
        .BlankHundreds (BlankHundreds),
        .BlankTens     (BlankTens)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [14:0] model(input logic [7:0] p);
        int   v;
        int   m;
        logic neg;
        logic [3:0] h, t, o;
        v   = (p >= 8'h80) ? int'(p) - 256 : int'(p);
        neg = (v < 0);
        m   = neg ? -v : v;
        h   = 4'(m / 100);
        t   = 4'((m / 10) % 10);
        o   = 4'(m % 10);
        return {neg, h, t, o, (h == 4'd0), (h == 4'd0 && t == 4'd0)};
    endfunction

    function automatic logic [14:0] observed();
        return {Negative, Hundreds, Tens, Ones, BlankHundreds, BlankTens};
    endfunction

    // Scoreboard: every Done pops the oldest expected result.
    always @(negedge Clock) begin
        if (!Reset && Done) begin
            done_count    <= done_count + 1;
            prev_done_cyc <= last_done_cyc;
            last_done_cyc <= cyc;
            compared      <= compared + 1;
            if (exp_q.size() == 0) begin
                mismatched <= mismatched + 1;
                $display("FAIL done_unexpected: got digits %h with no pending conversion",
                         observed());
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                last_exp <= e;
                if (observed() !== e) begin
                    mismatched <= mismatched + 1;
                    $display("FAIL done_result: got %h expected %h", observed(), e);
                end
            end
        end
    end

    // Issues one Start pulse and returns cycles-to-Done and Busy-high count.
    task automatic run_conv(input logic [7:0] p, output int lat, output int busy_cyc);
        @(posedge Clock); #1;
        Start   = 1'b1;
        Product = p;
        exp_q.push_back(model(p));
        @(posedge Clock); #1;
        Start    = 1'b0;
        Product  = 8'(~p);
        lat      = 0;
        busy_cyc = Busy ? 1 : 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge Clock); #1;
            if (Busy) busy_cyc++;
            if (Done) begin
                lat = i;
                break;
            end
        end
        @(negedge Clock);
    endtask

    task automatic check_timing(input string name, input int lat, input int busy_cyc);
        compared++;
        if (lat !== 9) begin
            mismatched++;
            $display("FAIL %s_latency: got %0d cycles expected 9", name, lat);
        end
        compared++;
        if (busy_cyc !== 9) begin
            mismatched++;
            $display("FAIL %s_busy: got %0d cycles expected 9", name, busy_cyc);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        compared++;
        if ({Busy, Done, observed()} !== {2'b00, 1'b0, 12'd0, 2'b11}) begin
            mismatched++;
            $display("FAIL reset_values: got %b expected %b",
                     {Busy, Done, observed()}, {2'b00, 1'b0, 12'd0, 2'b11});
        end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [7:0] vals [5] = '{8'h00, 8'h40, 8'hC8, 8'h80, 8'h7F};
        foreach (vals[i]) begin
            run_conv(vals[i], lat, bc);
            check_timing($sformatf("conv_%h", vals[i]), lat, bc);
        end
    endtask

    task automatic test_hold();
        logic [14:0] held;
        held = observed();
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock); #1;
            Product = 8'($urandom_range(0, 255));
        end
        @(negedge Clock);
        compared++;
        if (observed() !== held || held !== last_exp) begin
            mismatched++;
            $display("FAIL hold_outputs: got %h expected %h", observed(), last_exp);
        end
    endtask

    task automatic test_ignore_start();
        int d0;
        d0 = done_count;
        @(posedge Clock); #1;
        Start   = 1'b1;
        Product = 8'h15;
        exp_q.push_back(model(8'h15));
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        Product = 8'hFF;
        Start   = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (25) @(posedge Clock);
        @(negedge Clock);
        compared++;
        if (done_count - d0 !== 1) begin
            mismatched++;
            $display("FAIL ignore_start: got %0d Done pulses expected 1", done_count - d0);
        end
    endtask

    task automatic test_reset_abort();
        int d0, lat, bc;
        @(posedge Clock); #1;
        Start   = 1'b1;
        Product = 8'h07;
        @(posedge Clock); #1;
        Start = 1'b0;
        d0 = done_count;
        repeat (4) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        compared++;
        if ({Busy, Done, observed()} !== {2'b00, 1'b0, 12'd0, 2'b11}) begin
            mismatched++;
            $display("FAIL abort_reset_values: got %b expected %b",
                     {Busy, Done, observed()}, {2'b00, 1'b0, 12'd0, 2'b11});
        end
        Reset = 1'b0;
        repeat (14) @(posedge Clock);
        @(negedge Clock);
        compared++;
        if (done_count !== d0 || Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_no_done: got %0d pulses busy %b expected 0 pulses busy 0",
                     done_count - d0, Busy);
        end
        last_exp = {1'b0, 12'd0, 1'b1, 1'b1};
        run_conv(8'hF9, lat, bc);
        check_timing("conv_f9", lat, bc);
    endtask

    task automatic test_reset_start_same_edge();
        @(posedge Clock); #1;
        Reset   = 1'b1;
        Start   = 1'b1;
        Product = 8'h33;
        @(posedge Clock); #1;
        Reset = 1'b0;
        Start = 1'b0;
        @(posedge Clock); #1;
        compared++;
        if ({Busy, observed()} !== {1'b0, 1'b0, 12'd0, 2'b11}) begin
            mismatched++;
            $display("FAIL reset_beats_start: got %b expected %b",
                     {Busy, observed()}, {1'b0, 1'b0, 12'd0, 2'b11});
        end
        last_exp = {1'b0, 12'd0, 1'b1, 1'b1};
    endtask

    task automatic test_back_to_back();
        int d0;
        bit ok;
        d0 = done_count;
        @(posedge Clock); #1;
        Start   = 1'b1;
        Product = 8'h01;
        exp_q.push_back(model(8'h01));
        repeat (10) @(posedge Clock);
        #1;
        Product = 8'hFE;
        exp_q.push_back(model(8'hFE));
        @(posedge Clock); #1;
        Start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (done_count - d0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge Clock);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL b2b_timeout: got %0d Done pulses expected 2", done_count - d0);
        end else if (last_done_cyc - prev_done_cyc !== 10) begin
            mismatched++;
            $display("FAIL b2b_spacing: got %0d cycles expected 10",
                     last_done_cyc - prev_done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_ignore_start();
        test_reset_abort();
        test_reset_start_same_edge();
        test_back_to_back();
        repeat (3) @(negedge Clock);
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/product_bcd_formatter.md
Name: product_bcd_formatter

Overview:
- Sequential signed-binary-to-BCD converter that sits directly downstream of the signed 4x4 multiplier core.
- Takes the 8-bit two's-complement product and produces sign, hundreds, tens and ones digits, plus leading-zero blank flags.
- These outputs feed the multiplexed seven-segment display stage, so the product is shown in decimal instead of hex.
- Conversion is iterative shift-add-3 (double-dabble), one bit per clock, under a Start/Busy/Done handshake.

Parameters:
- WIDTH, 8, width of the signed input product; legal range 4..9 (magnitude ≤ 256 fits 3 BCD digits).

Ports:
- Clock  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request conversion of Product; sampled only in IDLE.
- Product  input  WIDTH  signed two's-complement value to convert.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when digit outputs update.
- Negative  output  1  sign of the last converted value.
- Hundreds  output  4  BCD hundreds digit.
- Tens  output  4  BCD tens digit.
- Ones  output  4  BCD ones digit.
- BlankHundreds  output  1  high when Hundreds == 0.
- BlankTens  output  1  high when Hundreds == 0 and Tens == 0.

Behaviour:
- Reset is synchronous and active-high, on the single clock Clock. The Reset port is active-high synchronous; Clock is the only clock.
- Reset values:
  - Busy = 0, Done = 0, Negative = 0.
  - Hundreds = Tens = Ones = 0.
  - BlankHundreds = 1, BlankTens = 1 (display shows "0").
  - FSM enters IDLE.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - On an edge with Start = 1: capture sign = Product[WIDTH-1].
  - Capture magnitude = sign ? (0 - Product) : Product, as WIDTH-bit unsigned. The most negative input gives 2^(WIDTH-1), e.g. 0x80 -> 128.
  - Clear the internal BCD scratch, load bit counter = WIDTH, go to SHIFT, and set Busy = 1 at the same edge.
  - With Start = 0, stay in IDLE.
- SHIFT, one bit per cycle:
  - For each scratch digit ≥ 5, add 3.
  - Then shift {scratch, magnitude} left by 1 and decrement the counter.
  - After the WIDTH-th shift, go to FINISH.
- FINISH, one cycle:
  - Register Negative, Hundreds/Tens/Ones and the blank flags from the scratch.
  - Done = 1 for exactly this cycle, Busy = 0, next state IDLE.
- Latency and throughput:
  - Start sampled at edge n -> outputs and Done valid after edge n+WIDTH+1 (9 cycles for WIDTH = 8).
  - Back-to-back: Start may be asserted in the Done cycle and is accepted at the next edge (IDLE).
  - Throughput: one conversion per WIDTH+2 cycles.
- Outputs hold their last converted values between conversions; they change only in FINISH or on Reset.
- Start while Busy = 1 is ignored, not queued. Product may change freely during a conversion without affecting the result.
- Negative zero is impossible: input 0 always yields Negative = 0.
- Reset asserted mid-conversion:
  - Aborts the conversion with no Done pulse.
  - All outputs return to reset values at that edge.
  - The FSM is in IDLE the next cycle.
- Start and Reset high on the same edge: Reset wins, Start is ignored.

Test Plan:
- Reset, then Start with Product = 0x00 -> after 9 cycles Done pulse; Negative = 0, digits 0/0/0, BlankHundreds = 1, BlankTens = 1.
- Product = 0x40 (+64, i.e. -8 x -8) -> Negative = 0, Hundreds = 0, Tens = 6, Ones = 4, BlankHundreds = 1, BlankTens = 0; Busy high exactly 9 cycles.
- Product = 0xC8 (-56) -> Negative = 1, digits 0/5/6. Then Product = 0x80 -> Negative = 1, digits 1/2/8, both blanks 0. Then 0x7F -> Negative = 0, digits 1/2/7.
- Start = 0x15 (+21), change Product to 0xFF mid-conversion and re-pulse Start at cycle 4 -> a single Done pulse, digits 0/2/1; the second Start is ignored.
- Start on 0x07, assert Reset at cycle 5 -> no Done pulse; all outputs at reset values; a fresh Start on 0xF9 (-7) converts to Negative = 1, digits 0/0/7.
- Back-to-back: Start held high continuously with Product stepping through 0x01, 0xFE -> Done pulses 10 cycles apart; results +1, then -2.
